// File: rtl/alu8bit_pkg.sv
// Shared definitions for the alu8bit instruction sequencer: instruction
// layout, multi-cycle opcodes and sequencer state encoding.
package alu8bit_pkg;

  localparam int unsigned INSTR_W = 18;
  localparam int unsigned OP_HI   = 17;
  localparam int unsigned OP_LO   = 15;

  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Multiply and divide need the start-pulse / wait sequence.
  function automatic logic is_multi(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; on a tie
// the requester that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_id,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_id
);

  // One-hot grant selection, suppressed entirely when not enabled.
  always_comb begin
    grant    = '0;
    grant_id = 1'b0;
    if (en) begin
      case (valid)
        2'b01: begin
          grant    = 2'b01;
          grant_id = 1'b0;
        end
        2'b10: begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end
        2'b11: begin
          if (last_id) begin
            grant    = 2'b01;
            grant_id = 1'b0;
          end else begin
            grant    = 2'b10;
            grant_id = 1'b1;
          end
        end
        default: begin
          grant    = '0;
          grant_id = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu8bit_sched.sv
// Sequencer and two-port arbiter in front of the alu8bit datapath. Accepts
// one instruction at a time, drives the ALU instr/start timing for single-
// and multi-cycle opcodes, captures the results and returns them tagged
// with the requester id.
module alu8bit_sched
  import alu8bit_pkg::*;
#(
  parameter int unsigned START_CYCLES = 4,
  parameter int unsigned MC_LAT       = 8,
  parameter int unsigned ALU_LAT      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [INSTR_W-1:0] req0_instr,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [INSTR_W-1:0] req1_instr,
  output logic               req1_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [7:0]         resp_result1,
  output logic [7:0]         resp_result2,
  output logic               resp_carry,
  output logic               resp_overflow,
  output logic               busy,
  output logic [INSTR_W-1:0] alu_instr,
  output logic               alu_start,
  input  logic [7:0]         alu_result1,
  input  logic [7:0]         alu_result2,
  input  logic               alu_carry,
  input  logic               alu_overflow
);

  localparam int unsigned CNT_MAX0 = (START_CYCLES > MC_LAT) ? START_CYCLES : MC_LAT;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > ALU_LAT) ? CNT_MAX0 : ALU_LAT;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t             state;
  logic               last_id;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         grant;
  logic               grant_id;
  logic               arb_en;
  logic [INSTR_W-1:0] grant_instr;

  // Gating with rst_n keeps both ready outputs low while reset is held.
  assign arb_en = rst_n && (state == ST_IDLE);

  rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .last_id  (last_id),
    .en       (arb_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign grant_instr = grant_id ? req1_instr : req0_instr;
  assign busy        = (state != ST_IDLE);

  // Sequencer: grant, drive ALU timing with one shared down-counter, capture, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_id       <= 1'b1;
      cnt           <= '0;
      alu_instr     <= '0;
      alu_start     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_result1  <= '0;
      resp_result2  <= '0;
      resp_carry    <= 1'b0;
      resp_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            alu_instr <= grant_instr;
            resp_id   <= grant_id;
            last_id   <= grant_id;
            if (is_multi(grant_instr[OP_HI:OP_LO])) begin
              state     <= ST_START;
              alu_start <= 1'b1;
              cnt       <= CNT_W'(START_CYCLES - 1);
            end else begin
              state <= ST_EXEC;
              cnt   <= CNT_W'(ALU_LAT - 1);
            end
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            resp_result1  <= alu_result1;
            resp_result2  <= alu_result2;
            resp_carry    <= alu_carry;
            resp_overflow <= alu_overflow;
            resp_valid    <= 1'b1;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            alu_start <= 1'b0;
            cnt       <= CNT_W'(MC_LAT - 1);
            state     <= ST_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            resp_result1  <= alu_result1;
            resp_result2  <= alu_result2;
            resp_carry    <= alu_carry;
            resp_overflow <= alu_overflow;
            resp_valid    <= 1'b1;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          alu_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu8bit_sched.md
# alu8bit_sched

Sequencer and two-port arbiter in front of the `alu8bit` datapath. Two requesters submit 18-bit ALU instructions over valid/ready handshakes. The block grants one request at a time, round-robin, and drives the ALU `instr` and `start` inputs with correct hold and start-pulse timing for both single-cycle and multi-cycle (multiply/divide) opcodes. It captures `result1`, `result2`, `carry` and `overflow`, then returns them on a shared response channel tagged with the requester id.

## Interface
- `START_CYCLES`, 4: cycles `alu_start` is held high for a multi-cycle opcode.
- `MC_LAT`, 8: cycles waited after `start` falls before multi-cycle results are valid.
- `ALU_LAT`, 1: cycles `alu_instr` is held before single-cycle results are valid (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request pending.
- `req0_instr` / `req1_instr` in 18: instruction; opcode = `instr[17:15]`.
- `req0_ready` / `req1_ready` out 1: handshake accept; combinational, only in IDLE.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts response.
- `resp_id` out 1: requester served (0/1).
- `resp_result1`, `resp_result2` out 8: captured ALU results.
- `resp_carry`, `resp_overflow` out 1: captured ALU flags.
- `busy` out 1: state ≠ IDLE.
- `alu_instr` out 18: to ALU `instr`; registered.
- `alu_start` out 1: to ALU `start`; registered.
- `alu_result1`, `alu_result2` in 8; `alu_carry`, `alu_overflow` in 1: from the ALU.

## Operation
- One transaction outstanding at a time; no pipelining.
- Multi-cycle opcodes are 3'b110 and 3'b111. All other opcodes are single-cycle.
- Arbitration happens only in IDLE:
  - One requester valid: it wins.
  - Both valid: the requester other than `last_id` wins.
  - `last_id` resets to 1, so req0 wins the first tie.
  - `last_id` updates on each grant.
  - The winner's `ready` = 1 that cycle. The loser's `ready` = 0.
- FSM states: IDLE, EXEC, START, WAIT, RESP.
- IDLE → EXEC on grant of a single-cycle opcode; IDLE → START on grant of a multi-cycle opcode. In both cases `alu_instr` ← granted instr and `resp_id` ← granted id.
- EXEC: hold `alu_instr` for ALU_LAT cycles. On the last cycle, capture ALU outputs into `resp_*`, then go to RESP.
- START: `alu_start` = 1 for exactly START_CYCLES cycles, then go to WAIT with `alu_start` = 0.
- WAIT: hold for MC_LAT cycles. On the last cycle, capture ALU outputs, then go to RESP.
- RESP: `resp_valid` = 1. Response fields stay stable until `resp_ready`. On `resp_valid && resp_ready`, go to IDLE.
- `alu_instr` keeps the last instruction while IDLE. It never changes during EXEC, START or WAIT.
- `req*_valid` and `req*_instr` changes outside IDLE are ignored.
- A single down-counter sized for max(START_CYCLES, MC_LAT, ALU_LAT) serves all timed states.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - state = IDLE, `last_id` = 1.
  - `alu_instr` = 0, `alu_start` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_result1/2` = 0, `resp_carry/overflow` = 0, `busy` = 0.
  - `req*_ready` = 0.
- Let cycle 0 be the handshake cycle:
  - Cycle 1: `alu_instr` = instr.
  - Single-cycle opcode: capture at the end of cycle ALU_LAT; `resp_valid` = 1 from cycle 1+ALU_LAT (cycle 2 at default).
  - Multi-cycle opcode: `alu_start` = 1 in cycles 1..START_CYCLES; capture at the end of cycle START_CYCLES+MC_LAT; `resp_valid` from cycle 1+START_CYCLES+MC_LAT (cycle 13 at default).
- Earliest next grant is the cycle after the `resp_valid && resp_ready` cycle. Back-to-back single-cycle throughput is one op per 3 cycles when `resp_ready` is held high.
- Reset asserted mid-operation: `alu_start` drops immediately. The in-flight transaction is discarded with no response, and the arbiter restarts with req0 priority.
- Both requests valid on the cycle the FSM returns to IDLE: grant goes to the opposite of `last_id`, with no idle bubble.

## Structure
- `alu8bit_pkg` holds:
  - Opcode field bounds (17:15).
  - `OP_MUL` = 3'b110, `OP_DIV` = 3'b111.
  - The FSM state encoding localparams.
  - Instruction width 18.
- Sub-module `rr_arb2`: 2-input round-robin arbiter. Inputs: `valid[1:0]`, `last_id`, `en`. Outputs: `grant[1:0]` one-hot, `grant_id`.
- All other logic lives in `alu8bit_sched`. The ALU is instantiated outside the block; the bench connects the real `alu8bit`.

## Test plan
- Single-cycle request: req0 `instr` = 18'b000000001000000001, `resp_ready` = 1. Expect `req0_ready` = 1 in cycle 0, `alu_instr` matches in cycle 1, `resp_valid` in cycle 2, `resp_id` = 0, and `resp_*` equal the ALU outputs sampled at the end of cycle 1.
- Multi-cycle request: req1 `instr` = 18'b110000001000000001. Expect `alu_start` high for exactly 4 cycles (1–4), `resp_valid` at cycle 13, `resp_id` = 1, and `alu_instr` unchanged through cycles 1–13.
- Contention: both valid every cycle, req0 = 18'b010000001000000001, req1 = 18'b100000001000000001. Expect grants in the order 0,1,0,1 and `resp_id` alternating.
- Backpressure: `resp_ready` = 0 for 5 cycles after `resp_valid`. Expect the response fields frozen, `req*_ready` = 0 and `busy` = 1 throughout; IDLE is reached the cycle after `resp_ready` = 1.
- Reset mid-op: assert `rst_n` = 0 at cycle 3 of a 3'b111 op. Expect `alu_start` = 0, `resp_valid` = 0 and `busy` = 0 immediately. After release, a tie grants req0.
- Input churn: change `req0_instr` during WAIT. Expect `alu_instr` unchanged and the response to reflect the originally accepted instruction.
